// File: rtl/st3_4_exmem_register.sv
// EX/MEM pipeline register: captures EX results, holds loads/stores for WAIT_CYCLES wait states.
// Optional stall-cycle counter enabled by defining EXMEM_STALL_CNT_EN.
module st3_4_exmem_register #(
    parameter int DATA_W      = 16,
    parameter int REG_W       = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [1:0]        ex_MemWrite,
    input  logic [1:0]        ex_MemRead,
    input  logic              ex_RegWrite,
    input  logic              ex_MemToReg,
    input  logic [DATA_W-1:0] ex_ALUResult,
    input  logic [DATA_W-1:0] ex_WriteData,
    input  logic [REG_W-1:0]  ex_WriteReg,
    input  logic              flush,
    output logic [1:0]        MemWrite,
    output logic [1:0]        MemRead,
    output logic [DATA_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    output logic              mem_valid,
    output logic              mem_done,
    output logic              RegWrite,
    output logic              MemToReg,
    output logic [REG_W-1:0]  WriteReg,
    output logic              stall_out,
    output logic              illegal_op,
    output logic [15:0]       stall_count
);

    typedef enum logic {PASS = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [3:0] W_INIT = 4'(WAIT_CYCLES);

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic                r_valid, r_regwrite, r_memtoreg, r_illegal;
    logic [1:0]          r_memwrite, r_memread;
    logic [DATA_W-1:0]   r_addr, r_wdata;
    logic [REG_W-1:0]    r_wreg;

    logic                w_wr_ill, w_rd_ill, w_ill;
    logic [1:0]          w_mw_cap, w_mr_cap;
    logic                w_memop_cap, w_capture;

    // An illegal encoding on either field demotes the whole instruction to a non-memop.
    assign w_wr_ill    = (ex_MemWrite == 2'b11);
    assign w_rd_ill    = (ex_MemRead == 2'b11);
    assign w_ill       = ex_valid & (w_wr_ill | w_rd_ill);
    assign w_mw_cap    = (ex_valid & ~w_ill) ? ex_MemWrite : 2'b00;
    assign w_mr_cap    = (ex_valid & ~w_ill & (ex_MemWrite == 2'b00)) ? ex_MemRead : 2'b00;
    assign w_memop_cap = (w_mw_cap != 2'b00) | (w_mr_cap != 2'b00);
    assign w_capture   = (r_state == PASS) & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PASS;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush) begin
            w_state_nxt = PASS;
            w_cnt_nxt   = 4'd0;
        end else if (r_state == PASS) begin
            if (w_memop_cap && (WAIT_CYCLES > 0)) begin
                w_state_nxt = WAIT;
                w_cnt_nxt   = W_INIT;
            end
        end else begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) w_state_nxt = PASS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_memwrite <= 2'b00;
            r_memread  <= 2'b00;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_illegal  <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wreg     <= '0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_memwrite <= 2'b00;
            r_memread  <= 2'b00;
            r_regwrite <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_capture) begin
            r_valid    <= ex_valid;
            r_memwrite <= w_mw_cap;
            r_memread  <= w_mr_cap;
            r_regwrite <= ex_valid & ex_RegWrite;
            r_memtoreg <= ex_valid & ex_MemToReg;
            r_illegal  <= w_ill;
            r_addr     <= ex_ALUResult;
            r_wdata    <= ex_WriteData;
            r_wreg     <= ex_WriteReg;
        end
    end

    // Stores reach memory only in the commit cycle, never while waiting.
    always_comb begin
        stall_out  = (r_state == WAIT);
        mem_done   = r_valid & (r_state == PASS);
        MemWrite   = mem_done ? r_memwrite : 2'b00;
        MemRead    = r_memread;
        mem_valid  = r_valid;
        RegWrite   = r_valid & r_regwrite;
        MemToReg   = r_valid & r_memtoreg;
        WriteReg   = r_valid ? r_wreg : '0;
        Address    = r_addr;
        WriteData  = r_wdata;
        illegal_op = r_illegal;
    end

`ifdef EXMEM_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= 16'h0000;
        else if ((r_state == WAIT) && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
    assign stall_count = r_stall_cnt;
`else
    assign stall_count = 16'h0000;
`endif

endmodule
